// File: rtl/int_to_fp_if.sv
// int_to_fp_if -- request/result bundle for the integer-to-binary32 converter.
//
// Handshake: in_valid qualifies a for exactly the cycle it is high. There is
// no ready; the converter accepts one operand every cycle. out_valid is a
// one-cycle pulse that qualifies q. q keeps its value while out_valid is low.
//
// Signals
//   in_valid  master->slave  1   a is a conversion request this cycle
//   a         master->slave  32  integer operand
//   out_valid slave->master  1   q holds a new result this cycle
//   q         slave->master  32  binary32 result
interface int_to_fp_if;
  logic        in_valid;
  logic [31:0] a;
  logic        out_valid;
  logic [31:0] q;

  modport master (output in_valid, output a, input out_valid, input q);
  modport slave  (input in_valid, input a, output out_valid, output q);
endinterface

// File: rtl/int_to_fp.sv
// int_to_fp -- pipelined 32-bit integer to IEEE-754 binary32 converter.
//
// Fixed latency of 3 cycles and one result per cycle. The pipeline never
// stalls. The operand is signed int32 when SIGNED=1 and uint32 when SIGNED=0.
// Rounding is to nearest, ties to even, or toward zero when TRUNCATE=1.
//
// Ports
//   clk     in   clock; all state changes on the rising edge
//   areset  in   synchronous active-high reset. It clears all valid flags
//                and q. Requests that are in flight are dropped.
//   bus     slave modport of int_to_fp_if (in_valid, a, out_valid, q)
//
// Pipeline
//   s1: sign, magnitude and zero flag
//   s2: leading-zero count of the magnitude
//   s3: normalised magnitude (bit 31 set unless zero)
//   out: rounding and packing into q
module int_to_fp #(
  parameter bit SIGNED   = 1'b1,
  parameter bit TRUNCATE = 1'b0
) (
  input  logic        clk,
  input  logic        areset,
  int_to_fp_if.slave  bus
);

  // Valid chain
  logic s1_valid, s2_valid, s3_valid, out_valid_r;

  // Stage 1 registers
  logic        s1_sign, s1_zero;
  logic [31:0] s1_mag;

  // Stage 2 registers
  logic        s2_sign, s2_zero;
  logic [31:0] s2_mag;
  logic [4:0]  s2_lz;

  // Stage 3 registers
  logic        s3_sign, s3_zero;
  logic [31:0] s3_norm;
  logic [4:0]  s3_lz;

  logic [31:0] q_r;

  // Stage 1 combinational
  logic        a_sign;
  logic [31:0] a_mag;

  always_comb begin
    a_sign = SIGNED && bus.a[31];
    // Two's-complement negate. 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude 2^31.
    a_mag  = a_sign ? (~bus.a + 32'd1) : bus.a;
  end

  // Stage 2 combinational: leading-zero count. Scanning upward lets the
  // highest set bit win. A zero magnitude yields 31, and the zero flag
  // discards that value downstream.
  logic [4:0] lz_cnt;

  always_comb begin
    lz_cnt = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag[i]) lz_cnt = 5'(31 - i);
    end
  end

  // Output stage combinational: round and pack
  logic [22:0] frac;
  logic        guard, sticky, round_up, carry;
  logic [22:0] frac_rnd;
  logic [7:0]  exp_rnd;
  logic [31:0] result;

  always_comb begin
    frac     = s3_norm[30:8];
    guard    = s3_norm[7];
    sticky   = |s3_norm[6:0];
    // Ties go to even: a pure tie rounds up only when the kept LSB is odd.
    round_up = !TRUNCATE && guard && (sticky || s3_norm[8]);
    {carry, frac_rnd} = {1'b0, frac} + {23'd0, round_up};
    // The exponent bias is 127 and the leading one sits at bit 31.
    // A carry out of the fraction leaves frac_rnd at zero and bumps the
    // exponent. The largest value reachable is 2^32, so no overflow occurs.
    exp_rnd  = 8'd158 - {3'd0, s3_lz} + {7'd0, carry};
    result   = s3_zero ? 32'h0000_0000 : {s3_sign, exp_rnd, frac_rnd};
  end

  // Valid chain: this is the only part of the pipeline that reset touches.
  always_ff @(posedge clk) begin
    if (areset) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      s3_valid    <= s2_valid;
      out_valid_r <= s3_valid;
    end
  end

  // Data stages load only when their input is valid. Their contents do not
  // matter otherwise, so they have no reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s1_sign <= a_sign;
      s1_mag  <= a_mag;
      s1_zero <= (bus.a == 32'd0);
    end
    if (s1_valid) begin
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_mag  <= s1_mag;
      s2_lz   <= lz_cnt;
    end
    if (s2_valid) begin
      s3_sign <= s2_sign;
      s3_zero <= s2_zero;
      s3_norm <= s2_mag << s2_lz;
      s3_lz   <= s2_lz;
    end
  end

  // q holds its last value between results.
  always_ff @(posedge clk) begin
    if (areset) begin
      q_r <= 32'h0000_0000;
    end else if (s3_valid) begin
      q_r <= result;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;

endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp -- self-checking bench for int_to_fp.
//
// It runs three instances side by side on the same operand stream:
//   sn: SIGNED=1 TRUNCATE=0
//   st: SIGNED=1 TRUNCATE=1
//   un: SIGNED=0 TRUNCATE=0
// The directed vectors carry literal expected results. The random operands
// are converted by an arithmetic reference model. A monitor on the falling
// edge pops the expected queue whenever a result appears.
module tb_int_to_fp;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int_to_fp_if if_sn ();
  int_to_fp_if if_st ();
  int_to_fp_if if_un ();

  int_to_fp #(.SIGNED(1'b1), .TRUNCATE(1'b0)) u_sn (.clk(clk), .areset(areset), .bus(if_sn));
  int_to_fp #(.SIGNED(1'b1), .TRUNCATE(1'b1)) u_st (.clk(clk), .areset(areset), .bus(if_st));
  int_to_fp #(.SIGNED(1'b0), .TRUNCATE(1'b0)) u_un (.clk(clk), .areset(areset), .bus(if_un));

  // ---------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] e_sn;
    logic [31:0] e_st;
    logic [31:0] e_un;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [31:0] last_sn = 32'h0, last_st = 32'h0, last_un = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the rounded binary32 value of the integer, computed from its
  // exact magnitude and the remainder below the 24-bit significand.
  function automatic logic [31:0] ref_cvt(input logic [31:0] v, input bit sgn, input bit trunc);
    logic        neg;
    logic [63:0] m, mant, rem, half;
    int          e, sh;
    neg = sgn && v[31];
    m   = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    if (m == 64'd0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 64'd0) e++;
    if (e <= 23) begin
      mant = m << (23 - e);
    end else begin
      sh   = e - 23;
      mant = m >> sh;
      rem  = m - (mant << sh);
      half = 64'd1 << (sh - 1);
      if (!trunc && (rem > half || (rem == half && mant[0]))) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        e++;
      end
    end
    return {neg, 8'(e + 127), mant[22:0]};
  endfunction

  // Monitor: compares each result against the queue head and its latency.
  // On idle cycles it checks that every lane holds its last result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (if_sn.out_valid === 1'b1 || if_st.out_valid === 1'b1 || if_un.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {29'd0, if_sn.out_valid, if_st.out_valid, if_un.out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("lat", cyc - e.cyc, 32'd3);
          check("ov_sn", {31'd0, if_sn.out_valid}, 32'd1);
          check("ov_st", {31'd0, if_st.out_valid}, 32'd1);
          check("ov_un", {31'd0, if_un.out_valid}, 32'd1);
          check("q_sn", if_sn.q, e.e_sn);
          check("q_st", if_st.q, e.e_st);
          check("q_un", if_un.q, e.e_un);
          last_sn = e.e_sn;
          last_st = e.e_st;
          last_un = e.e_un;
        end
      end else begin
        check("idle_ov", {29'd0, if_sn.out_valid, if_st.out_valid, if_un.out_valid}, 32'd0);
        check("hold_sn", if_sn.q, last_sn);
        check("hold_st", if_st.q, last_st);
        check("hold_un", if_un.q, last_un);
      end
      // The next edge samples reset, so it drops everything in flight and
      // clears q.
      if (areset === 1'b1) begin
        exp_q.delete();
        last_sn = 32'h0;
        last_st = 32'h0;
        last_un = 32'h0;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic v, input logic [31:0] a);
    if_sn.in_valid = v; if_sn.a = a;
    if_st.in_valid = v; if_st.a = a;
    if_un.in_valid = v; if_un.a = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_exp(input logic [31:0] a, input logic [31:0] e_sn,
                          input logic [31:0] e_st, input logic [31:0] e_un);
    exp_t e;
    drive(1'b1, a);
    e.cyc  = cyc + 1;
    e.e_sn = e_sn;
    e.e_st = e_st;
    e.e_un = e_un;
    exp_q.push_back(e);
    step();
  endtask

  task automatic send(input logic [31:0] a);
    send_exp(a, ref_cvt(a, 1'b1, 1'b0), ref_cvt(a, 1'b1, 1'b1), ref_cvt(a, 1'b0, 1'b0));
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0);
    repeat (n) step();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin
        v = 32'($urandom_range(0, 32'h00FF_FFFF));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      2: v = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 7)) - 32'd4;
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------- sequence
  initial begin
    areset = 1'b1;
    drive(1'b0, 32'h0);
    repeat (3) step();

    // Reset state
    check("rst_ov_sn", {31'd0, if_sn.out_valid}, 32'd0);
    check("rst_q_sn", if_sn.q, 32'h0);
    check("rst_ov_un", {31'd0, if_un.out_valid}, 32'd0);
    check("rst_q_st", if_st.q, 32'h0);
    areset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Back-to-back: 1, -1, 0
    send_exp(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    send_exp(32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000, 32'h4F80_0000);
    send_exp(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    idle(6);

    // Extremes: INT_MIN, and INT_MAX, whose rounding carries into the exponent
    send_exp(32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000, 32'h4F00_0000);
    send_exp(32'h7FFF_FFFF, 32'h4F00_0000, 32'h4EFF_FFFF, 32'h4F00_0000);
    idle(2);

    // Ties to even, down and up
    send_exp(32'h0100_0001, 32'h4B80_0000, 32'h4B80_0000, 32'h4B80_0000);
    send_exp(32'h0100_0003, 32'h4B80_0002, 32'h4B80_0001, 32'h4B80_0002);
    send_exp(32'h00FF_FFFF, 32'h4B7F_FFFF, 32'h4B7F_FFFF, 32'h4B7F_FFFF);
    idle(6);

    // Reset mid-flight. A request issued together with reset is ignored.
    send(32'h1234_5678);
    send(32'hDEAD_BEEF);
    send(32'h0000_0005);
    areset = 1'b1;
    drive(1'b1, 32'h0000_0007);
    step();
    check("flush_ov", {31'd0, if_sn.out_valid}, 32'd0);
    check("flush_q", if_sn.q, 32'h0);
    areset = 1'b0;
    idle(2);
    send_exp(32'hFFFF_FFFE, 32'hC000_0000, 32'hC000_0000, 32'h4F80_0000);
    idle(6);

    // Random operands with idle gaps
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send(rand_operand());
    end
    idle(8);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
